// File: rtl/alu_run_pkg.sv
// Shared constants for the MiniAlu run monitor:
// FSM encoding, error saturation and the "no error" index.
package alu_run_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_RST  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] ERR_SAT = 8'd255;

  // Sliced to the index width at the point of use.
  localparam logic [31:0] NO_ERR = '1;

endpackage

// File: rtl/alu_run_if.sv
// Control, table-load, LED and result bundle of the run monitor.
// slave = the monitor, master = whoever drives and reads it.
interface alu_run_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  logic             iStart;
  logic             iWrEn;
  logic [AW-1:0]    iWrAddr;
  logic [WIDTH-1:0] iWrData;
  logic [IW-1:0]    iExpCount;
  logic [WIDTH-1:0] iLed;
  logic             oDutReset;
  logic             oBusy;
  logic             oDone;
  logic             oPass;
  logic [7:0]       oErrCount;
  logic [IW-1:0]    oFirstErrIdx;
  logic [IW-1:0]    oEventCount;

  modport slave (
    input  iStart, iWrEn, iWrAddr,
    input  iWrData, iExpCount, iLed,
    output oDutReset, oBusy, oDone,
    output oPass, oErrCount,
    output oFirstErrIdx, oEventCount
  );

  modport master (
    output iStart, iWrEn, iWrAddr,
    output iWrData, iExpCount, iLed,
    input  oDutReset, oBusy, oDone,
    input  oPass, oErrCount,
    input  oFirstErrIdx, oEventCount
  );

endinterface

// File: rtl/run_exp_table.sv
// Expected LED signature table: register file with
// synchronous write and combinational read.
module run_exp_table #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_run_monitor.sv
// Run controller: pre-wait, DUT reset pulse, bounded run window,
// LED change capture against the expected table, on-chip verdict.
module alu_run_monitor
  import alu_run_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int PRE_CYCLES  = 10,
  parameter int RST_CYCLES  = 5,
  parameter int RUN_CYCLES  = 100,
  parameter int STOP_ON_ALL = 0,
  parameter int CNT_W       = 16
) (
  input logic Clock,
  input logic Reset,
  alu_run_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(RUN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DEPTH);
  localparam logic [IW-1:0] NOERR = NO_ERR[IW-1:0];

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0]    expcnt, expcnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [IW-1:0]    ferr, ferr_n;
  logic [7:0]       errs, errs_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WIDTH-1:0] exp_led;
  logic             dutrst, busy, done, pass;
  logic             pass_n, wr_ok, ev, hit_err;

  assign wr_ok = bus.iWrEn && (state == S_IDLE);

  run_exp_table #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_tab (
    .clk  (Clock),
    .we   (wr_ok),
    .waddr(bus.iWrAddr),
    .wdata(bus.iWrData),
    .raddr(idx[AW-1:0]),
    .rdata(exp_led)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    expcnt_n = expcnt;
    idx_n    = idx;
    ferr_n   = ferr;
    errs_n   = errs;
    prev_n   = prev;
    ev       = 1'b0;
    hit_err  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.iStart) begin
          state_n  = (PRE_CYCLES == 0) ? S_RST : S_PRE;
          cnt_n    = '0;
          expcnt_n = bus.iExpCount;
          idx_n    = '0;
          ferr_n   = NOERR;
          errs_n   = '0;
        end
      end
      S_PRE: begin
        if (cnt == PRE_LAST) begin
          state_n = S_RST;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RST: begin
        if (cnt == RST_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
          prev_n  = bus.iLed;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RUN: begin
        ev = (bus.iLed != prev);
        if (ev) begin
          prev_n  = bus.iLed;
          // past expcnt every change is unexpected
          hit_err = (idx >= expcnt) ||
                    (bus.iLed != exp_led);
          if (idx != IDX_MAX) idx_n = idx + 1'b1;
          if (hit_err) begin
            if (errs != ERR_SAT) errs_n = errs + 1'b1;
            if (errs == '0) ferr_n = idx;
          end
        end
        cnt_n = cnt + 1'b1;
        if (cnt == RUN_LAST) state_n = S_DONE;
        if ((STOP_ON_ALL != 0) && (idx == expcnt) &&
            (errs == '0))
          state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pass_n = (errs_n == '0) && (idx_n == expcnt_n);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      expcnt <= '0;
      idx    <= '0;
      ferr   <= NOERR;
      errs   <= '0;
      prev   <= '0;
      dutrst <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      expcnt <= expcnt_n;
      idx    <= idx_n;
      ferr   <= ferr_n;
      errs   <= errs_n;
      prev   <= prev_n;
      dutrst <= (state_n == S_RST);
      busy   <= state_n inside {S_PRE, S_RST, S_RUN};
      done   <= (state_n == S_DONE);
      pass   <= (state_n == S_DONE) && pass_n;
    end
  end

  assign bus.oDutReset    = dutrst;
  assign bus.oBusy        = busy;
  assign bus.oDone        = done;
  assign bus.oPass        = pass;
  assign bus.oErrCount    = errs;
  assign bus.oFirstErrIdx = ferr;
  assign bus.oEventCount  = idx;

endmodule

// File: tb/tb_alu_run_monitor.sv
// Scoreboard bench for alu_run_monitor: three instances
// (default, early-stop, long run) driven by directed LED traces.
module tb_alu_run_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_run_if #(.WIDTH(8), .DEPTH(16)) b0 ();
  alu_run_if #(.WIDTH(8), .DEPTH(16)) b1 ();
  alu_run_if #(.WIDTH(8), .DEPTH(16)) b2 ();

  alu_run_monitor u0 (.Clock(clk), .Reset(rst), .bus(b0));
  alu_run_monitor #(.STOP_ON_ALL(1)) u1 (
    .Clock(clk), .Reset(rst), .bus(b1));
  alu_run_monitor #(.RUN_CYCLES(1000)) u2 (
    .Clock(clk), .Reset(rst), .bus(b2));

  typedef struct {
    string tag;
    int    pass;
    int    err;
    int    first;
    int    evt;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  int rc;
  logic d0q = 1'b0, d1q = 1'b0, d2q = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic cmp(input exp_t e, input logic p,
                     input logic [7:0] ec,
                     input logic [4:0] fi,
                     input logic [4:0] ev);
    chk({e.tag, " pass"}, 32'(p), 32'(e.pass));
    chk({e.tag, " errcount"}, 32'(ec), 32'(e.err));
    chk({e.tag, " firsterr"}, 32'(fi), 32'(e.first));
    chk({e.tag, " events"}, 32'(ev), 32'(e.evt));
  endtask

  // Monitors: pop on each rising oDone
  always @(negedge clk) begin
    if (b0.oDone && !d0q) begin
      if (q0.size() == 0) chk("u0 unexpected done", 1, 0);
      else cmp(q0.pop_front(), b0.oPass, b0.oErrCount,
               b0.oFirstErrIdx, b0.oEventCount);
    end
    d0q <= b0.oDone;
  end

  always @(negedge clk) begin
    if (b1.oDone && !d1q) begin
      if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
      else cmp(q1.pop_front(), b1.oPass, b1.oErrCount,
               b1.oFirstErrIdx, b1.oEventCount);
    end
    d1q <= b1.oDone;
  end

  always @(negedge clk) begin
    if (b2.oDone && !d2q) begin
      if (q2.size() == 0) chk("u2 unexpected done", 1, 0);
      else cmp(q2.pop_front(), b2.oPass, b2.oErrCount,
               b2.oFirstErrIdx, b2.oEventCount);
    end
    d2q <= b2.oDone;
  end

  function automatic logic drst(input int w);
    case (w)
      0:       return b0.oDutReset;
      1:       return b1.oDutReset;
      default: return b2.oDutReset;
    endcase
  endfunction

  function automatic logic dn(input int w);
    case (w)
      0:       return b0.oDone;
      1:       return b1.oDone;
      default: return b2.oDone;
    endcase
  endfunction

  task automatic drive(input int w, input logic st,
                       input logic we,
                       input logic [3:0] a,
                       input logic [7:0] d,
                       input logic [4:0] ec);
    case (w)
      0: begin
        b0.iStart = st; b0.iWrEn = we; b0.iWrAddr = a;
        b0.iWrData = d; b0.iExpCount = ec;
      end
      1: begin
        b1.iStart = st; b1.iWrEn = we; b1.iWrAddr = a;
        b1.iWrData = d; b1.iExpCount = ec;
      end
      default: begin
        b2.iStart = st; b2.iWrEn = we; b2.iWrAddr = a;
        b2.iWrData = d; b2.iExpCount = ec;
      end
    endcase
  endtask

  task automatic set_led(input int w, input logic [7:0] v);
    case (w)
      0:       b0.iLed = v;
      1:       b1.iLed = v;
      default: b2.iLed = v;
    endcase
  endtask

  task automatic wr(input int w, input logic [3:0] a,
                    input logic [7:0] d);
    drive(w, 1'b0, 1'b1, a, d, 5'd0);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0);
  endtask

  task automatic start(input int w, input logic [4:0] ec);
    drive(w, 1'b1, 1'b0, 4'd0, 8'd0, ec);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0);
  endtask

  // Returns on the negedge of RUN cycle 1 (rc = 1)
  task automatic run_to(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 60 && !drst(w); i++) @(negedge clk);
    while (drst(w) && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("dut reset width", n, 5);
    rc = 1;
  endtask

  task automatic led_at(input int w, input int cyc,
                        input logic [7:0] v);
    while (rc < cyc) begin
      @(negedge clk);
      rc++;
    end
    set_led(w, v);
  endtask

  task automatic wait_done(input int w, input int want);
    while (!dn(w) && rc < 1200) begin
      @(negedge clk);
      rc++;
    end
    chk("run length", rc, want);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      drive(w, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0);
      set_led(w, 8'h00);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(b0.oBusy), 0);
    chk("reset done", 32'(b0.oDone), 0);
    chk("reset dutrst", 32'(b0.oDutReset), 0);
    chk("reset pass", 32'(b0.oPass), 0);
    chk("reset errcount", 32'(b0.oErrCount), 0);
    chk("reset events", 32'(b0.oEventCount), 0);
    chk("reset firsterr", 32'(b0.oFirstErrIdx), 31);
    @(posedge clk); #1;
    rst = 1'b0;

    wr(0, 4'd0, 8'h01);
    wr(0, 4'd1, 8'h02);
    wr(0, 4'd2, 8'h04);

    // basic pass
    q0.push_back('{"basic", 1, 0, 31, 3});
    start(0, 5'd3);
    run_to(0);
    led_at(0, 3, 8'h01);
    led_at(0, 5, 8'h02);
    led_at(0, 7, 8'h04);
    wait_done(0, 101);

    // mismatch at idx 1, plus a start while busy
    set_led(0, 8'h00);
    q0.push_back('{"mismatch", 0, 1, 1, 3});
    start(0, 5'd3);
    run_to(0);
    led_at(0, 3, 8'h01);
    led_at(0, 5, 8'h03);
    led_at(0, 7, 8'h04);
    led_at(0, 20, 8'h04);
    drive(0, 1'b1, 1'b0, 4'd0, 8'd0, 5'd0);
    @(negedge clk);
    rc++;
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0);
    chk("busy start ignored", 32'(b0.oBusy), 1);
    wait_done(0, 101);

    // table write in DONE must be dropped
    wr(0, 4'd1, 8'h03);

    // reset mid-run
    set_led(0, 8'h00);
    start(0, 5'd3);
    run_to(0);
    led_at(0, 3, 8'h01);
    led_at(0, 10, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(b0.oBusy), 0);
    chk("midrst dutrst", 32'(b0.oDutReset), 0);
    chk("midrst done", 32'(b0.oDone), 0);
    chk("midrst events", 32'(b0.oEventCount), 0);
    chk("midrst errcount", 32'(b0.oErrCount), 0);
    chk("midrst firsterr", 32'(b0.oFirstErrIdx), 31);
    rst = 1'b0;

    // rerun on preserved table
    set_led(0, 8'h00);
    q0.push_back('{"rerun", 1, 0, 31, 3});
    start(0, 5'd3);
    run_to(0);
    led_at(0, 3, 8'h01);
    led_at(0, 5, 8'h02);
    led_at(0, 7, 8'h04);
    wait_done(0, 101);

    // extra change beyond expcount
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr(0, 4'd0, 8'hAA);
    wr(0, 4'd1, 8'h55);
    set_led(0, 8'h00);
    q0.push_back('{"extra", 0, 1, 2, 3});
    start(0, 5'd2);
    run_to(0);
    led_at(0, 3, 8'hAA);
    led_at(0, 5, 8'h55);
    led_at(0, 7, 8'hFF);
    wait_done(0, 101);

    // early stop
    wr(1, 4'd0, 8'h80);
    q1.push_back('{"early", 1, 0, 31, 1});
    start(1, 5'd1);
    run_to(1);
    led_at(1, 3, 8'h80);
    wait_done(1, 5);

    // error saturation with expcount 0
    q2.push_back('{"saturate", 0, 255, 0, 16});
    start(2, 5'd0);
    run_to(2);
    for (int i = 0; i < 300; i++)
      led_at(2, 2 + i, (i % 2 == 0) ? 8'hFF : 8'h00);
    wait_done(2, 1001);

    repeat (3) @(negedge clk);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    chk("u2 queue drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
